ext_com_top: RTL and testbench
==============================

# ext_com_top

Self-contained two-master / two-slave shared-bus demonstrator. It contains two burst masters, a fixed-priority arbiter, one shared address/data bus and two byte-wide slave memories. A 5-bit scenario code launched by `start` selects which master reads or writes which slave. It is the top level of the external-communication bus test setup and has no bus pins of its own; results are exposed on small status outputs.

## Interface
Parameters:
- `BURSTN`, 16: beats per burst.
- `BEAT_CYCLES`, 4: clock cycles per beat.
- `BASE_ADDR`, 12'd1365 (12'h555): first address of every burst.
- `M1_DATA0`, 8'd170 (8'hAA): master 1 first write byte.
- `M2_DATA0`, 8'd85 (8'h55): master 2 first write byte.
- `SLAVE_DEPTH`, 4096: bytes per slave memory.

Ports:
- `clk` in 1: single clock; everything is synchronous to the rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: launch request, level-sampled.
- `state_in` in 5: scenario code.
- `busy` out 1: scenario in progress.
- `done` out 1: one-cycle pulse when a scenario finishes.
- `grant` out 2: bus owner; 01 = M1, 10 = M2, 00 = none.
- `m1_rd_last`, `m2_rd_last` out 8 each: last byte read by M1 / M2.
- `m1_rd_sum`, `m2_rd_sum` out 8 each: modulo-256 sum of bytes read in the most recent read burst.

## Operation
Scenarios (M = master, S = slave, R = read, W = write):
- 0: M1 W S2.
- 1: M1 R S2.
- 2: M1 R S2 + M2 W S2.
- 3: M1 R S2 + M2 W S1.
- 4: M1 R S2 + M2 R S2.
- 5: M1 W S2 + M2 W S2.
- 6: M1 R S1 + M2 R S2.
- 7: M1 W S1 + M2 R S1.
- 8: M1 R S1 + M2 W S1.
- 9: M1 W S2 + M2 W S1.
- 10-31: no-op. `busy` goes high for one cycle, then `done` pulses; there is no bus activity.

Burst rules:
- Beat i (0..BURSTN-1) uses address BASE_ADDR+i.
- A write beat stores `Mx_DATA0+i` (mod 256).
- A slave stores bytes at `addr % SLAVE_DEPTH`.
- Memory is not cleared by reset; its contents are undefined until written.

Arbitration:
- Both masters of a scenario raise their requests in the same cycle.
- M1 has fixed priority. M2 waits until M1's burst has been released.
- Grant is held for a whole burst; there is no preemption.

Read results:
- A read burst clears its master's `rd_sum` at grant.
- Each beat adds the read byte to `rd_sum` and loads it into `rd_last`.
- Results hold until that master's next read burst or reset.

Controller FSM: IDLE → LAUNCH → ARB → GRANT → BEAT (×BURSTN) → RELEASE → ARB (if a request is pending) or DONE → IDLE.
- `state_in` is latched in LAUNCH.
- `start` is ignored while `busy` is high. Holding `start` across several cycles launches exactly one scenario.
- A new launch needs `start` low for at least one cycle after `done`.

Reset (async, active-high) forces:
- the FSM to IDLE;
- `busy`=0, `done`=0, `grant`=00;
- all `rd_last` / `rd_sum` to 0;
- any pending requests to be dropped.

If reset is asserted mid-burst, writes already completed stay in memory and the remaining beats are abandoned.

## Timing
- `start` is sampled at clock edge E0; `busy` is high from E0+1.
- Each burst lasts 1 grant cycle + BURSTN×BEAT_CYCLES beat cycles + 1 release cycle, i.e. 66 cycles with the defaults.
- Write beat timing: address and data are valid on beat cycle 0; the slave writes on the edge closing beat cycle 1.
- Read beat timing: address is valid on beat cycle 0; data returns in beat cycle 2 and is captured on the edge closing beat cycle 2; beat cycle 3 is bus turnaround.
- `done` pulse timing:
  - single-master scenario: E0+67;
  - two-master scenario: E0+133;
  - no-op: E0+2.
- `busy` falls in the same cycle as `done`.
- `grant` is 00 outside GRANT/BEAT cycles.

## Test plan
- Scenario 0, then scenario 1 → `m1_rd_last`=0xB9, `m1_rd_sum`=0x18; `done` pulses at E0+67 on each run.
- Scenario 0, then scenario 2 → M1 reads the old data first (0xB9 / 0x18); a following scenario 1 gives 0x64 / 0xC8 (M2's data).
- Scenario 5, then scenario 4 → both masters read 0x64 / 0xC8. `grant` sequence is 01 then 10; `done` pulses at E0+133.
- Scenario 9, then scenario 6 → M1 (S1) reads 0x64 / 0xC8; M2 (S2) reads 0xB9 / 0x18.
- `start` held high for 2 cycles, plus a second `start` pulse while busy → exactly one scenario runs; scenario 15 pulses `done` at E0+2 with `grant` staying 00.
- Reset asserted during beat 5 of scenario 1 → all outputs go to 0 immediately and the FSM returns to IDLE; a relaunched scenario 1 completes normally.

Source files
------------

// File: rtl/ext_com_top.sv
// ext_com_top: two burst masters, fixed-priority arbiter, shared bus, two byte slaves.
// Ports: clk, reset (async high), start/state_in launch, busy/done/grant status, mX_rd_last/sum results.
module ext_com_top #(
    parameter int          BURSTN      = 16,
    parameter int          BEAT_CYCLES = 4,
    parameter logic [11:0] BASE_ADDR   = 12'h555,
    parameter logic [7:0]  M1_DATA0    = 8'hAA,
    parameter logic [7:0]  M2_DATA0    = 8'h55,
    parameter int          SLAVE_DEPTH = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] state_in,
    output logic       busy,
    output logic       done,
    output logic [1:0] grant,
    output logic [7:0] m1_rd_last,
    output logic [7:0] m2_rd_last,
    output logic [7:0] m1_rd_sum,
    output logic [7:0] m2_rd_sum
);
    localparam int BW = (BURSTN > 1) ? $clog2(BURSTN) : 1;
    localparam int CW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int AW = (SLAVE_DEPTH > 1) ? $clog2(SLAVE_DEPTH) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURSTN - 1);
    localparam logic [CW-1:0] LAST_CYC  = CW'(BEAT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_ARB,
        S_GRANT,
        S_BEAT,
        S_RELEASE,
        S_DONE
    } state_t;

    typedef struct packed {
        logic m1_on;
        logic m1_wr;
        logic m1_s2;
        logic m2_on;
        logic m2_wr;
        logic m2_s2;
    } scen_t;

    function automatic scen_t decode(input logic [4:0] code);
        scen_t s;
        s = '0;
        case (code)
            5'd0:    s = 6'b111_000;
            5'd1:    s = 6'b101_000;
            5'd2:    s = 6'b101_111;
            5'd3:    s = 6'b101_110;
            5'd4:    s = 6'b101_101;
            5'd5:    s = 6'b111_111;
            5'd6:    s = 6'b100_101;
            5'd7:    s = 6'b110_100;
            5'd8:    s = 6'b100_110;
            5'd9:    s = 6'b111_110;
            default: s = '0;
        endcase
        return s;
    endfunction

    state_t        state_q;
    logic [4:0]    scen_q;
    logic          req1;
    logic          req2;
    logic          armed;
    logic [BW-1:0] beat_idx;
    logic [CW-1:0] cyc;

    scen_t sc;
    scen_t din;
    scen_t nsc;
    logic  launching;
    logic  nreq1;
    logic  nreq2;
    logic  arb_m1;
    logic  arb_m2;
    logic  arb_any;

    assign sc        = decode(scen_q);
    assign din       = decode(state_in);
    assign launching = (state_q == S_LAUNCH);
    // During LAUNCH the scenario is still on state_in, not yet in scen_q.
    assign nsc       = launching ? din : sc;
    assign nreq1     = launching ? nsc.m1_on : req1;
    assign nreq2     = launching ? nsc.m2_on : req2;
    assign arb_m1    = nreq1;
    assign arb_m2    = !nreq1 && nreq2;
    assign arb_any   = arb_m1 || arb_m2;

    logic        cur_m2;
    logic        cur_wr;
    logic        cur_s2;
    logic        in_beat;
    logic [11:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_we;
    logic        bus_re;
    logic        cap;
    logic [AW-1:0] mem_idx;
    logic [7:0]  s1_rdata;
    logic [7:0]  s2_rdata;
    logic [7:0]  rdata;

    assign cur_m2    = grant[1];
    assign cur_wr    = cur_m2 ? sc.m2_wr : sc.m1_wr;
    assign cur_s2    = cur_m2 ? sc.m2_s2 : sc.m1_s2;
    assign in_beat   = (state_q == S_BEAT);
    assign bus_addr  = BASE_ADDR + 12'(beat_idx);
    assign bus_wdata = (cur_m2 ? M2_DATA0 : M1_DATA0) + 8'(beat_idx);
    assign bus_we    = in_beat && cur_wr && (cyc == CW'(1));
    assign bus_re    = in_beat && !cur_wr && (cyc == CW'(1));
    // Slave data is registered at the end of beat cycle 1, valid in cycle 2.
    assign cap       = in_beat && !cur_wr && (cyc == CW'(2));
    assign mem_idx   = AW'({20'd0, bus_addr} % 32'(SLAVE_DEPTH));
    assign rdata     = cur_s2 ? s2_rdata : s1_rdata;

    // Slave memories: never reset, so completed writes survive a reset.
    logic [7:0] s1_mem [SLAVE_DEPTH];
    logic [7:0] s2_mem [SLAVE_DEPTH];

    always_ff @(posedge clk) begin
        if (bus_we && !cur_s2) s1_mem[mem_idx] <= bus_wdata;
        if (bus_we && cur_s2)  s2_mem[mem_idx] <= bus_wdata;
        if (bus_re && !cur_s2) s1_rdata <= s1_mem[mem_idx];
        if (bus_re && cur_s2)  s2_rdata <= s2_mem[mem_idx];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            scen_q     <= '0;
            req1       <= 1'b0;
            req2       <= 1'b0;
            armed      <= 1'b0;
            beat_idx   <= '0;
            cyc        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            grant      <= 2'b00;
            m1_rd_last <= 8'd0;
            m2_rd_last <= 8'd0;
            m1_rd_sum  <= 8'd0;
            m2_rd_sum  <= 8'd0;
        end else begin
            if (cap) begin
                if (cur_m2) begin
                    m2_rd_last <= rdata;
                    m2_rd_sum  <= m2_rd_sum + rdata;
                end else begin
                    m1_rd_last <= rdata;
                    m1_rd_sum  <= m1_rd_sum + rdata;
                end
            end
            case (state_q)
                S_IDLE: begin
                    // A launch needs start seen low in IDLE first.
                    if (!start) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        armed   <= 1'b0;
                        state_q <= S_LAUNCH;
                    end
                end
                S_LAUNCH, S_ARB, S_RELEASE: begin
                    if (launching) begin
                        scen_q <= state_in;
                        busy   <= 1'b1;
                    end
                    // Arbitration resolves on the exit edge so the winner
                    // owns the bus on the very next cycle.
                    if (arb_any) begin
                        state_q <= S_GRANT;
                        grant   <= arb_m1 ? 2'b01 : 2'b10;
                        req1    <= nreq1 && !arb_m1;
                        req2    <= nreq2 && !arb_m2;
                        if (arb_m1 && !nsc.m1_wr) m1_rd_sum <= 8'd0;
                        if (arb_m2 && !nsc.m2_wr) m2_rd_sum <= 8'd0;
                    end else if (launching) begin
                        req1    <= 1'b0;
                        req2    <= 1'b0;
                        state_q <= S_ARB;
                    end else begin
                        state_q <= S_DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                S_GRANT: begin
                    state_q  <= S_BEAT;
                    beat_idx <= '0;
                    cyc      <= '0;
                end
                S_BEAT: begin
                    if (cyc == LAST_CYC) begin
                        cyc <= '0;
                        if (beat_idx == LAST_BEAT) begin
                            state_q <= S_RELEASE;
                            grant   <= 2'b00;
                        end else begin
                            beat_idx <= beat_idx + BW'(1);
                        end
                    end else begin
                        cyc <= cyc + CW'(1);
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ext_com_top.sv
// tb_ext_com_top: directed scenarios against a burst-level model of ext_com_top.
// Checks status/results every cycle plus hand-computed literals.
module tb_ext_com_top;
    localparam int          BURSTN = 16;
    localparam int          BEATC  = 4;
    localparam int          BL     = 2 + BURSTN * BEATC;
    localparam int          DEPTH  = 4096;
    localparam logic [11:0] BASE   = 12'h555;
    localparam logic [7:0]  D1     = 8'hAA;
    localparam logic [7:0]  D2     = 8'h55;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [4:0] state_in;
    logic       busy;
    logic       done;
    logic [1:0] grant;
    logic [7:0] m1_rd_last;
    logic [7:0] m2_rd_last;
    logic [7:0] m1_rd_sum;
    logic [7:0] m2_rd_sum;

    int checks = 0;
    int failures = 0;
    int edge_n = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    ext_com_top dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .state_in(state_in),
        .busy(busy),
        .done(done),
        .grant(grant),
        .m1_rd_last(m1_rd_last),
        .m2_rd_last(m2_rd_last),
        .m1_rd_sum(m1_rd_sum),
        .m2_rd_sum(m2_rd_sum)
    );

    // Burst-level model
    logic [7:0] ms1 [DEPTH];
    logic [7:0] ms2 [DEPTH];
    int   t0 = -100000;
    int   td = 2;
    int   nb = 0;
    int   bm [2];
    int   bw [2];
    int   bs [2];
    bit   mon_en = 1'b0;
    logic [7:0] bef_last [2];
    logic [7:0] bef_sum [2];
    logic [7:0] aft_last [2];
    logic [7:0] aft_sum [2];
    bit   rd_has [2];
    int   rd_lo [2];
    int   rd_hi [2];
    logic [1:0] gq [$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, edge_n - t0);
        end
    endtask

    task automatic add_burst(input int m, input int w, input int s);
        bm[nb] = m;
        bw[nb] = w;
        bs[nb] = s;
        nb++;
    endtask

    task automatic model_launch(input int code);
        int mi;
        int a;
        logic [7:0] d;
        logic [7:0] last;
        logic [7:0] sum;
        for (int m = 0; m < 2; m++) begin
            if (rd_has[m]) begin
                bef_last[m] = aft_last[m];
                bef_sum[m]  = aft_sum[m];
            end
            rd_has[m] = 1'b0;
        end
        nb = 0;
        case (code)
            0: add_burst(1, 1, 2);
            1: add_burst(1, 0, 2);
            2: begin add_burst(1, 0, 2); add_burst(2, 1, 2); end
            3: begin add_burst(1, 0, 2); add_burst(2, 1, 1); end
            4: begin add_burst(1, 0, 2); add_burst(2, 0, 2); end
            5: begin add_burst(1, 1, 2); add_burst(2, 1, 2); end
            6: begin add_burst(1, 0, 1); add_burst(2, 0, 2); end
            7: begin add_burst(1, 1, 1); add_burst(2, 0, 1); end
            8: begin add_burst(1, 0, 1); add_burst(2, 1, 1); end
            9: begin add_burst(1, 1, 2); add_burst(2, 1, 1); end
            default: ;
        endcase
        for (int b = 0; b < nb; b++) begin
            mi = bm[b] - 1;
            last = 8'd0;
            sum = 8'd0;
            for (int i = 0; i < BURSTN; i++) begin
                a = (int'(BASE) + i) % DEPTH;
                if (bw[b] != 0) begin
                    d = ((mi == 0) ? D1 : D2) + 8'(i);
                    if (bs[b] == 1) ms1[a] = d;
                    else ms2[a] = d;
                end else begin
                    d = (bs[b] == 1) ? ms1[a] : ms2[a];
                    last = d;
                    sum = sum + d;
                end
            end
            if (bw[b] == 0) begin
                rd_has[mi]   = 1'b1;
                aft_last[mi] = last;
                aft_sum[mi]  = sum;
                rd_lo[mi]    = 1 + BL * b;
                rd_hi[mi]    = BL * (b + 1);
            end
        end
        td = (nb == 0) ? 2 : BL * nb + 1;
        t0 = edge_n + 1;
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (mon_en) begin : cmp
            int t;
            logic [1:0] eg;
            logic [7:0] el;
            logic [7:0] es;
            t = edge_n - t0;
            chk("busy", int'(busy), int'(t >= 1 && t < td));
            chk("done", int'(done), int'(t == td));
            eg = 2'b00;
            for (int b = 0; b < nb; b++)
                if (t >= 1 + BL * b && t < BL * (b + 1))
                    eg = (bm[b] == 1) ? 2'b01 : 2'b10;
            chk("grant", int'(grant), int'(eg));
            for (int m = 0; m < 2; m++) begin
                if (!(rd_has[m] && t >= rd_lo[m] && t < rd_hi[m])) begin
                    el = (rd_has[m] && t >= rd_hi[m]) ? aft_last[m] : bef_last[m];
                    es = (rd_has[m] && t >= rd_hi[m]) ? aft_sum[m] : bef_sum[m];
                    if (m == 0) begin
                        chk("m1_rd_last", int'(m1_rd_last), int'(el));
                        chk("m1_rd_sum", int'(m1_rd_sum), int'(es));
                    end else begin
                        chk("m2_rd_last", int'(m2_rd_last), int'(el));
                        chk("m2_rd_sum", int'(m2_rd_sum), int'(es));
                    end
                end
            end
        end
    end

    task automatic launch(input int code, input int hold);
        @(posedge clk);
        #2;
        model_launch(code);
        start = 1'b1;
        state_in = 5'(code);
        repeat (hold) @(posedge clk);
        #2 start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_t);
        int seen;
        seen = -1;
        gq.delete();
        for (int k = 0; k < 400 && seen < 0; k++) begin
            @(negedge clk);
            if (grant != 2'b00 && (gq.size() == 0 || gq[$] != grant))
                gq.push_back(grant);
            if (done === 1'b1) seen = edge_n - t0;
        end
        chk(name, seen, exp_t);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset_now();
        mon_en = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst grant", int'(grant), 0);
        chk("rst m1_last", int'(m1_rd_last), 0);
        chk("rst m1_sum", int'(m1_rd_sum), 0);
        chk("rst m2_last", int'(m2_rd_last), 0);
        chk("rst m2_sum", int'(m2_rd_sum), 0);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        for (int m = 0; m < 2; m++) begin
            bef_last[m] = 8'd0;
            bef_sum[m] = 8'd0;
            rd_has[m] = 1'b0;
        end
        nb = 0;
        td = 2;
        t0 = edge_n - 1000;
        repeat (3) @(posedge clk);
        #2 mon_en = 1'b1;
    endtask

    task automatic chk_rd(input string name, input int m, input int el, input int es);
        if (m == 1) begin
            chk({name, " m1_last"}, int'(m1_rd_last), el);
            chk({name, " m1_sum"}, int'(m1_rd_sum), es);
        end else begin
            chk({name, " m2_last"}, int'(m2_rd_last), el);
            chk({name, " m2_sum"}, int'(m2_rd_sum), es);
        end
    endtask

    initial begin
        int cnt;
        reset = 1'b0;
        start = 1'b0;
        state_in = 5'd0;
        #3;
        do_reset_now();

        launch(0, 1);
        wait_done("s0 done", 67);
        launch(1, 1);
        wait_done("s1 done", 67);
        chk_rd("s1", 1, 'hB9, 'h18);

        launch(0, 1);
        wait_done("s0b done", 67);
        launch(2, 1);
        wait_done("s2 done", 133);
        chk_rd("s2", 1, 'hB9, 'h18);
        launch(1, 1);
        wait_done("s1b done", 67);
        chk_rd("s1b", 1, 'h64, 'hC8);

        launch(5, 1);
        wait_done("s5 done", 133);
        launch(4, 1);
        wait_done("s4 done", 133);
        chk("s4 grant count", gq.size(), 2);
        if (gq.size() == 2) begin
            chk("s4 grant first", int'(gq[0]), 1);
            chk("s4 grant second", int'(gq[1]), 2);
        end
        chk_rd("s4", 1, 'h64, 'hC8);
        chk_rd("s4", 2, 'h64, 'hC8);

        launch(9, 1);
        wait_done("s9 done", 133);
        launch(6, 1);
        wait_done("s6 done", 133);
        chk_rd("s6", 1, 'h64, 'hC8);
        chk_rd("s6", 2, 'hB9, 'h18);

        // start held two cycles, then a stray pulse while busy
        launch(1, 2);
        repeat (8) @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        wait_done("held done", 67);
        cnt = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (done === 1'b1) cnt++;
        end
        chk("held extra dones", cnt, 0);
        chk_rd("held", 1, 'hB9, 'h18);

        launch(15, 1);
        wait_done("s15 done", 2);
        chk("s15 grants", gq.size(), 0);

        // reset in beat 5 of a read burst
        launch(1, 1);
        for (int k = 0; k < 100 && (edge_n - t0) < 23; k++) @(negedge clk);
        chk("mid m1_last", int'(m1_rd_last), 'hAE);
        chk("mid m1_sum", int'(m1_rd_sum), 'h5C);
        chk("mid busy", int'(busy), 1);
        do_reset_now();
        launch(1, 1);
        wait_done("post-rst done", 67);
        chk_rd("post-rst", 1, 'hB9, 'h18);
        chk_rd("post-rst", 2, 0, 0);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
